// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int         BIN_W_DEF  = 11;
  localparam int         DIGITS_DEF = 4;
  localparam logic [3:0] BLANK_CODE = 4'hF;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble correction cell: a nibble of 5 or more gets +3 before the shift.
module bcd_add3 (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  assign digit_o = (digit_i > 4'd4) ? digit_i + 4'd3 : digit_i;

endmodule

// File: rtl/bcd_convert_seq.sv
// Sequential double-dabble converter: one add-3/shift iteration per clock, start/busy/done handshake.
// Define BCD_BLANK_EN to replace leading zero digits with the display blank code on output load.
module bcd_convert_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = BIN_W_DEF,
  parameter int DIGITS = DIGITS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BIN_W-1:0] binary,
  output logic             busy,
  output logic             done,
  output logic [3:0]       thousands,
  output logic [3:0]       hundreds,
  output logic [3:0]       tens,
  output logic [3:0]       ones
);

  localparam int BCD_W = DIGITS * 4;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = (BIN_W < 2) ? 1 : $clog2(BIN_W);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_W - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SR_W-1:0]    sr_q, sr_d;
  logic [BCD_W-1:0]   dig_q, dig_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [BCD_W-1:0]   bcd_adj;
  logic [SR_W-1:0]    sr_corr;
  logic [SR_W-1:0]    sr_shift;

  // Leading zeros become BLANK_CODE from the most significant digit down; ones always shows.
  function automatic logic [BCD_W-1:0] out_load(input logic [BCD_W-1:0] raw);
    logic [BCD_W-1:0] res;
    res = raw;
`ifdef BCD_BLANK_EN
    begin
      logic lead;
      lead = 1'b1;
      for (int i = DIGITS - 1; i > 0; i--) begin
        if (lead && (raw[i*4 +: 4] == 4'd0)) begin
          res[i*4 +: 4] = BLANK_CODE;
        end else begin
          lead = 1'b0;
        end
      end
    end
`endif
    return res;
  endfunction

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .digit_i (sr_q[BIN_W + g*4 +: 4]),
      .digit_o (bcd_adj[g*4 +: 4])
    );
  end

  // Correction first, then the shift, all within one iteration.
  assign sr_corr  = {bcd_adj, sr_q[BIN_W-1:0]};
  assign sr_shift = {sr_corr[SR_W-2:0], 1'b0};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    dig_d   = dig_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          sr_d    = {{BCD_W{1'b0}}, binary};
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sr_d  = sr_shift;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_ITER) begin
          state_d = DONE;
        end
      end
      DONE: begin
        dig_d   = out_load(sr_q[SR_W-1:BIN_W]);
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      dig_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      dig_q   <= dig_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign thousands = dig_q[12 +: 4];
  assign hundreds  = dig_q[8 +: 4];
  assign tens      = dig_q[4 +: 4];
  assign ones      = dig_q[0 +: 4];

endmodule

// File: tb/tb_bcd_convert_seq.sv
// Self-checking bench for bcd_convert_seq: vector table plus handshake corner sequences.
module tb_bcd_convert_seq;

  typedef struct packed {
    logic [10:0] bin;
    logic [3:0]  th;
    logic [3:0]  hu;
    logic [3:0]  te;
    logic [3:0]  on;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [10:0] binary;
  logic        busy, done;
  logic [3:0]  thousands, hundreds, tens, ones;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  longint t_prev = 0, t_last = 0;
  vec_t sb[$];
  vec_t held;
  vec_t exp_v;
  vec_t tbl[12];

  always #5 clk = ~clk;

  bcd_convert_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .binary    (binary),
    .busy      (busy),
    .done      (done),
    .thousands (thousands),
    .hundreds  (hundreds),
    .tens      (tens),
    .ones      (ones)
  );

  function automatic vec_t blank(input vec_t v);
    vec_t r;
    r = v;
`ifdef BCD_BLANK_EN
    if (r.th == 4'd0) begin
      r.th = 4'hF;
      if (r.hu == 4'd0) begin
        r.hu = 4'hF;
        if (r.te == 4'd0) r.te = 4'hF;
      end
    end
`endif
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, got, want);
    end
  endtask

  // Scoreboard consumer: every done pulse must match the oldest accepted request.
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      t_prev = t_last;
      t_last = $time;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got done with %0h%0h%0h%0h, required no pulse",
                 thousands, hundreds, tens, ones);
      end else begin
        exp_v = sb.pop_front();
        if ({thousands, hundreds, tens, ones} !== {exp_v.th, exp_v.hu, exp_v.te, exp_v.on}) begin
          errors++;
          $display("FAIL digits(%0d): got %h,%h,%h,%h required %h,%h,%h,%h", exp_v.bin,
                   thousands, hundreds, tens, ones, exp_v.th, exp_v.hu, exp_v.te, exp_v.on);
        end
      end
    end
  end

  task automatic run_conv(input vec_t v);
    int lat;
    int busy_bad;
    lat = -1;
    busy_bad = 0;
    @(posedge clk);
    #1 binary = v.bin; start = 1'b1;
    sb.push_back(v);
    @(posedge clk);
    #1 start = 1'b0; binary = 11'($urandom);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
      if (!busy) busy_bad++;
      if (k == 6) chk("hold_mid_conv", {thousands, hundreds, tens, ones},
                      {held.th, held.hu, held.te, held.on});
      @(posedge clk);
    end
    chk("latency", lat, 12);
    chk("busy_during", busy_bad, 0);
    chk("busy_at_done", busy, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk("done_one_cycle", done, 1'b0);
    held = v;
  endtask

  initial begin
    int base;
    tbl[0]  = '{11'd1234, 4'd1, 4'd2, 4'd3, 4'd4};
    tbl[1]  = '{11'd0,    4'd0, 4'd0, 4'd0, 4'd0};
    tbl[2]  = '{11'd2047, 4'd2, 4'd0, 4'd4, 4'd7};
    tbl[3]  = '{11'd7,    4'd0, 4'd0, 4'd0, 4'd7};
    tbl[4]  = '{11'd42,   4'd0, 4'd0, 4'd4, 4'd2};
    tbl[5]  = '{11'd999,  4'd0, 4'd9, 4'd9, 4'd9};
    tbl[6]  = '{11'd1000, 4'd1, 4'd0, 4'd0, 4'd0};
    tbl[7]  = '{11'd305,  4'd0, 4'd3, 4'd0, 4'd5};
    tbl[8]  = '{11'd860,  4'd0, 4'd8, 4'd6, 4'd0};
    tbl[9]  = '{11'd100,  4'd0, 4'd1, 4'd0, 4'd0};
    tbl[10] = '{11'd9,    4'd0, 4'd0, 4'd0, 4'd9};
    tbl[11] = '{11'd1599, 4'd1, 4'd5, 4'd9, 4'd9};

    rst = 1'b1; start = 1'b0; binary = '0;
    held = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_digits", {thousands, hundreds, tens, ones}, 16'h0000);
    base = done_cnt;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("idle_busy", busy, 1'b0);
    chk("idle_no_done", done_cnt, base);

    for (int i = 0; i < 12; i++) run_conv(blank(tbl[i]));

    // Start while busy: ignored, single done, original result.
    base = done_cnt;
    @(posedge clk);
    #1 binary = 11'd1234; start = 1'b1;
    sb.push_back(blank(tbl[0]));
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 binary = 11'd999; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (25) @(posedge clk);
    @(negedge clk);
    chk("busy_start_single_done", done_cnt, base + 1);
    chk("busy_start_idle", busy, 1'b0);
    held = blank(tbl[0]);

    // Back-to-back with start held high; binary re-sampled at the first IDLE edge.
    base = done_cnt;
    @(posedge clk);
    #1 binary = 11'd305; start = 1'b1;
    sb.push_back(blank(tbl[7]));
    @(posedge clk);
    #1 binary = 11'd860;
    sb.push_back(blank(tbl[8]));
    repeat (13) @(posedge clk);
    #1 start = 1'b0; binary = '0;
    for (int i = 0; i < 40; i++) begin
      if (done_cnt >= base + 2) break;
      @(posedge clk);
    end
    chk("b2b_done_count", done_cnt, base + 2);
    chk("b2b_spacing_ns", 32'(t_last - t_prev), 32'd130);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("b2b_no_third", busy, 1'b0);
    held = blank(tbl[8]);

    // Simultaneous rst and start: rst wins.
    base = done_cnt;
    @(posedge clk);
    #1 rst = 1'b1; start = 1'b1; binary = 11'd5;
    @(posedge clk);
    #1 rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("rst_start_busy", busy, 1'b0);
    chk("rst_start_digits", {thousands, hundreds, tens, ones}, 16'h0000);
    repeat (15) @(posedge clk);
    chk("rst_start_no_done", done_cnt, base);
    held = '0;

    // Reset mid-conversion: abort, no done, digits cleared.
    run_conv(blank(tbl[0]));
    base = done_cnt;
    @(posedge clk);
    #1 binary = 11'd1500; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 1'b0);
    chk("abort_digits", {thousands, hundreds, tens, ones}, 16'h0000);
    repeat (15) @(posedge clk);
    @(negedge clk);
    chk("abort_no_done", done_cnt, base);
    held = '0;
    run_conv(blank('{11'd1500, 4'd1, 4'd5, 4'd0, 4'd0}));

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required finish before 200000 ns");
    $fatal(1, "timeout");
  end

endmodule
